// File: rtl/clk_mon_pkg.sv
// Shared definitions for the slow-clock period monitor: FSM encoding,
// default counter width and a saturating increment helper.
package clk_mon_pkg;

    localparam int CNT_W_DEF = 28;

    typedef enum logic [1:0] {
        ST_SEEK  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } mon_state_e;

    // Wide operands so any counter width can use it; callers cast the result back.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
        if (v >= max_v) begin
            return max_v;
        end else begin
            return v + 64'd1;
        end
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous level plus single-cycle
// rise/fall pulses; edges are suppressed until the chain holds real data.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_d_q;
    logic                   s_d_d;
    logic [SYNC_STAGES:0]   fill_q;
    logic [SYNC_STAGES:0]   fill_d;
    logic                   s_s;
    logic                   primed_s;

    // Next-state for the synchronizer, delayed copy and priming shift register.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        s_d_d  = sync_q[SYNC_STAGES-1];
        fill_d = {fill_q[SYNC_STAGES-1:0], 1'b1};
    end

    // Edge pulses; a level already present at reset release is not an edge.
    always_comb begin
        s_s      = sync_q[SYNC_STAGES-1];
        primed_s = fill_q[SYNC_STAGES];
        rise     = primed_s & s_s & ~s_d_q;
        fall     = primed_s & ~s_s & s_d_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            s_d_q  <= 1'b0;
            fill_q <= {(SYNC_STAGES+1){1'b0}};
        end else begin
            sync_q <= sync_d;
            s_d_q  <= s_d_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/clk_period_monitor.sv
// Measures period and high time of a slow fabric clock in clkin cycles,
// reports lock on repeated identical measurements and stall on missing edges.
module clk_period_monitor
    import clk_mon_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter int               SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT     = 28'd1_000_000,
    parameter int               LOCK_COUNT  = 4
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             clk_mon,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             stall
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_COUNT);

    logic rise_s;
    logic fall_s;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clkin),
        .rst  (rst),
        .din  (clk_mon),
        .rise (rise_s),
        .fall (fall_s)
    );

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             stall_q, stall_d;
    logic [3:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             same_s;

    // Helper values shared by every state.
    always_comb begin
        cnt_inc_s = CNT_W'(sat_inc(64'(cnt_q), 64'(CNT_MAX)));
        same_s    = (cnt_q == period_q) && (hi_lat_q == high_time_q);
    end

    // Next-state and output logic; a rise always takes priority over timeout.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_lat_d     = hi_lat_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        stall_d      = stall_q;
        stable_d     = stable_q;
        case (state_q)
            ST_SEEK: begin
                if (rise_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_RUN;
                end else if (cnt_q >= TIMEOUT) begin
                    state_d  = ST_STALL;
                    stall_d  = 1'b1;
                    locked_d = 1'b0;
                    stable_d = 4'd0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_RUN: begin
                if (rise_s) begin
                    period_d     = cnt_q;
                    high_time_d  = hi_lat_q;
                    meas_valid_d = 1'b1;
                    cnt_d        = CNT_ONE;
                    if (same_s) begin
                        stable_d = 4'(sat_inc(64'(stable_q), 64'(LOCK_N)));
                    end else begin
                        stable_d = 4'd0;
                    end
                    locked_d = (stable_d == LOCK_N);
                end else if (cnt_q >= TIMEOUT) begin
                    state_d  = ST_STALL;
                    stall_d  = 1'b1;
                    locked_d = 1'b0;
                    stable_d = 4'd0;
                end else begin
                    cnt_d = cnt_inc_s;
                    if (fall_s) begin
                        hi_lat_d = cnt_q;
                    end else begin
                        hi_lat_d = hi_lat_q;
                    end
                end
            end
            ST_STALL: begin
                // The interval spanning the stall is never reported.
                if (rise_s) begin
                    stall_d = 1'b0;
                    cnt_d   = CNT_ONE;
                    state_d = ST_RUN;
                end else begin
                    stall_d = 1'b1;
                    state_d = ST_STALL;
                end
            end
            default: begin
                state_d = ST_SEEK;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q      <= ST_SEEK;
            cnt_q        <= CNT_ZERO;
            hi_lat_q     <= CNT_ZERO;
            period_q     <= CNT_ZERO;
            high_time_q  <= CNT_ZERO;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            stall_q      <= 1'b0;
            stable_q     <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_lat_q     <= hi_lat_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            stall_q      <= stall_d;
            stable_q     <= stable_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign stall      = stall_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed and random waveforms on clk_mon, checked against a model that
// derives expected measurements from the drive times of rises and falls.
module tb_clk_period_monitor;

    localparam int CW = 28;
    localparam int TO = 64;
    localparam int LK = 4;

    logic          clkin   = 1'b0;
    logic          rst     = 1'b1;
    logic          clk_mon = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          locked;
    logic          stall;

    clk_period_monitor #(
        .CNT_W      (CW),
        .SYNC_STAGES(2),
        .TIMEOUT    (28'd64),
        .LOCK_COUNT (LK)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .clk_mon    (clk_mon),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .stall      (stall)
    );

    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct {
        int p;
        int h;
        bit lk;
    } meas_t;

    meas_t obs_q[$];
    meas_t exp_q[$];

    always @(negedge clkin) begin
        if (meas_valid) obs_q.push_back('{int'(period), int'(high_time), locked});
    end

    int total = 0;
    int bad   = 0;

    // Reference model state: drive-time bookkeeping only.
    bit m_run;
    bit m_level = 1'b0;
    int m_last_rise;
    int m_last_fall;
    int m_lp;
    int m_lh;
    int m_stable;

    function automatic void model_reset();
        m_run    = 1'b0;
        m_lp     = 0;
        m_lh     = 0;
        m_stable = 0;
        exp_q.delete();
    endfunction

    function automatic void model_edge(bit lvl, int t);
        int p;
        int h;
        if (lvl && !m_level) begin
            if (m_run && (t - m_last_rise) <= TO) begin
                p = t - m_last_rise;
                h = m_last_fall - m_last_rise;
                if (p == m_lp && h == m_lh) m_stable = (m_stable < LK) ? m_stable + 1 : LK;
                else m_stable = 0;
                m_lp = p;
                m_lh = h;
                exp_q.push_back('{p, h, (m_stable == LK)});
            end else if (m_run) begin
                m_stable = 0;
            end
            m_run       = 1'b1;
            m_last_rise = t;
        end else if (!lvl && m_level) begin
            m_last_fall = t;
        end
        m_level = lvl;
    endfunction

    task automatic chk(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic seg(input bit lvl, input int n);
        model_edge(lvl, cyc);
        clk_mon = lvl;
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic wave(input int h, input int l, input int n);
        repeat (n) begin
            seg(1'b1, h);
            seg(1'b0, l);
        end
    endtask

    task automatic cmp_meas(input string tag);
        int n;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_period[%0d]", tag, i), obs_q[i].p, exp_q[i].p);
            chk($sformatf("%s_high[%0d]", tag, i), obs_q[i].h, exp_q[i].h);
            chk($sformatf("%s_locked[%0d]", tag, i), int'(obs_q[i].lk), int'(exp_q[i].lk));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_high"}, int'(high_time), 0);
        chk({tag, "_mv"}, int'(meas_valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_stall"}, int'(stall), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst     = 1'b1;
        clk_mon = 1'b0;
        repeat (3) @(posedge clkin);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;

        // Held low from reset: SEEK times out into stall.
        repeat (40) @(posedge clkin);
        #1;
        chk("seek_stall_early", int'(stall), 0);
        repeat (60) @(posedge clkin);
        #1;
        chk("seek_stall_late", int'(stall), 1);
        chk("seek_locked", int'(locked), 0);
        chk("seek_period", int'(period), 0);
        cmp_meas("seek");

        // Square wave 8/2: lock on the fifth measurement.
        wave(2, 6, 8);
        seg(1'b0, 6);
        chk("sq8_stall", int'(stall), 0);
        chk("sq8_locked", int'(locked), 1);
        chk("sq8_period", int'(period), 8);
        chk("sq8_high", int'(high_time), 2);
        cmp_meas("sq8");

        // Switch to 10/5: lock drops, then returns.
        wave(5, 5, 7);
        seg(1'b0, 6);
        chk("sq10_locked", int'(locked), 1);
        chk("sq10_period", int'(period), 10);
        chk("sq10_high", int'(high_time), 5);
        cmp_meas("sq10");

        // Lock at 8, freeze high, resume.
        wave(2, 6, 8);
        seg(1'b1, 40);
        chk("frz_locked_before", int'(locked), 1);
        chk("frz_stall_early", int'(stall), 0);
        seg(1'b1, 60);
        chk("frz_stall", int'(stall), 1);
        chk("frz_locked", int'(locked), 0);
        chk("frz_period", int'(period), 8);
        seg(1'b0, 3);
        seg(1'b1, 2);
        seg(1'b0, 6);
        chk("frz_resume_stall", int'(stall), 0);
        seg(1'b1, 2);
        seg(1'b0, 6);
        cmp_meas("frz");

        // Reset during a high phase.
        seg(1'b1, 6);
        cmp_meas("pre_rst");
        rst = 1'b1;
        model_reset();
        @(posedge clkin);
        #1;
        chk_zero_outputs("midrst");
        obs_q.delete();
        rst = 1'b0;
        seg(1'b1, 3);
        seg(1'b0, 5);
        wave(3, 5, 1);
        chk("midrst_first_rise_nomeas", obs_q.size(), 0);
        wave(3, 5, 5);
        seg(1'b0, 6);
        cmp_meas("midrst");

        // Period exactly at TIMEOUT, then one cycle beyond it.
        wave(10, 54, 4);
        chk("to64_stall", int'(stall), 0);
        chk("to64_period", int'(period), 64);
        seg(1'b1, 10);
        seg(1'b0, 55);
        seg(1'b1, 10);
        seg(1'b0, 54);
        seg(1'b1, 10);
        seg(1'b0, 54);
        seg(1'b1, 10);
        seg(1'b0, 6);
        cmp_meas("to64");

        // Random pattern bursts with occasional long gaps.
        for (int i = 0; i < 25; i++) begin
            int h;
            int l;
            int k;
            h = $urandom_range(1, 12);
            l = $urandom_range(1, 12);
            k = $urandom_range(1, 7);
            if ($urandom_range(0, 9) == 0) seg(1'b0, 70);
            wave(h, l, k);
        end
        seg(1'b0, 6);
        cmp_meas("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
